alarm_output_driver: RTL and testbench

- Downstream of the anti-theft FSM. Consumes its level-type siren and status requests and drives the physical outputs.
- Siren output is a two-tone warble square wave. A maximum-sound-time cutoff latches the siren off until the request drops.
- Status LED is re-registered. Optional arm chirp on the status rising edge.

---
 rtl/alarm_output_driver_if.sv | 44 ++++
 rtl/alarm_output_driver.sv | 228 ++++++++++++++++++++++
 tb/tb_alarm_output_driver.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_output_driver_if.sv
// -----------------------------------------------------------------------------
// alarm_output_driver_if
//
// Purpose: groups the request levels coming from the anti-theft FSM and the
// physical alarm outputs into one bundle.
//
// Signals:
//   sirenRequest  - siren level requested by the anti-theft FSM
//   statusRequest - status-indicator level requested by the anti-theft FSM
//   sirenDrive    - modulated square wave to the siren transducer
//   sirenActive   - high while the siren is sounding
//   sirenTimedOut - high while the siren is held off by the max-sound cutoff
//   statusLed     - registered copy of statusRequest
//
// Modports:
//   master - the requesting side (drives requests, observes outputs)
//   slave  - the output driver itself
// -----------------------------------------------------------------------------
interface alarm_output_driver_if;
  logic sirenRequest;
  logic statusRequest;
  logic sirenDrive;
  logic sirenActive;
  logic sirenTimedOut;
  logic statusLed;

  modport master (
    output sirenRequest,
    output statusRequest,
    input  sirenDrive,
    input  sirenActive,
    input  sirenTimedOut,
    input  statusLed
  );

  modport slave (
    input  sirenRequest,
    input  statusRequest,
    output sirenDrive,
    output sirenActive,
    output sirenTimedOut,
    output statusLed
  );
endinterface

// File: rtl/alarm_output_driver.sv
// -----------------------------------------------------------------------------
// alarm_output_driver
//
// Purpose: turns the level-type siren/status requests of the anti-theft FSM
// into physical outputs. The siren is a two-tone warble square wave that is
// cut off after a maximum continuous sounding time and stays off until the
// request drops. The status LED is a registered copy of its request.
//
// Optional feature: define ALARM_CHIRP_EN to add a short tone-A arm chirp on
// every rising edge of statusRequest seen while idle.
//
// Ports:
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - alarm_output_driver_if.slave
//             sirenRequest, statusRequest (in)
//             sirenDrive, sirenActive, sirenTimedOut, statusLed (out)
// -----------------------------------------------------------------------------
module alarm_output_driver #(
  parameter int TICK_DIV     = 50000,
  parameter int TONE_A_HALF  = 25000,
  parameter int TONE_B_HALF  = 33333,
  parameter int WARBLE_TICKS = 250,
  parameter int MAX_ON_TICKS = 60000,
  parameter int CHIRP_TICKS  = 50
) (
  input  logic                 clock,
  input  logic                 reset,
  alarm_output_driver_if.slave bus
);

  localparam int HALF_MAX = (TONE_A_HALF > TONE_B_HALF) ? TONE_A_HALF : TONE_B_HALF;
  localparam int TICK_W   = (TICK_DIV     > 1) ? $clog2(TICK_DIV)     : 1;
  localparam int HALF_W   = (HALF_MAX     > 1) ? $clog2(HALF_MAX)     : 1;
  localparam int WARB_W   = (WARBLE_TICKS > 1) ? $clog2(WARBLE_TICKS) : 1;
  localparam int ON_W     = (MAX_ON_TICKS > 1) ? $clog2(MAX_ON_TICKS) : 1;

  // Counters compare against their last value, so the terminal value itself
  // never has to be representable in the counter.
  localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_A_LAST = HALF_W'(TONE_A_HALF - 1);
  localparam logic [HALF_W-1:0] HALF_B_LAST = HALF_W'(TONE_B_HALF - 1);
  localparam logic [WARB_W-1:0] WARB_LAST   = WARB_W'(WARBLE_TICKS - 1);
  localparam logic [ON_W-1:0]   ON_LAST     = ON_W'(MAX_ON_TICKS - 1);

  // An illegal parameter set shows up as this named block in elaboration.
  if (TICK_DIV < 1 || WARBLE_TICKS < 1 || MAX_ON_TICKS < 1 || CHIRP_TICKS < 1 ||
      TONE_A_HALF < 2 || TONE_B_HALF < 2) begin : gBadParams
  end

`ifdef ALARM_CHIRP_EN
  localparam int CHIRP_W = (CHIRP_TICKS > 1) ? $clog2(CHIRP_TICKS) : 1;
  localparam logic [CHIRP_W-1:0] CHIRP_LAST = CHIRP_W'(CHIRP_TICKS - 1);

  typedef enum logic [1:0] {IDLE, SOUNDING, CUTOFF, CHIRP} state_t;

  logic [CHIRP_W-1:0] chirpCnt_q, chirpCnt_d;
`else
  typedef enum logic [1:0] {IDLE, SOUNDING, CUTOFF} state_t;
`endif

  state_t             state_q, state_d;
  logic [TICK_W-1:0]  tickCnt_q, tickCnt_d;
  logic [HALF_W-1:0]  halfCnt_q, halfCnt_d;
  logic [WARB_W-1:0]  warbleCnt_q, warbleCnt_d;
  logic [ON_W-1:0]    onTicks_q, onTicks_d;
  logic               toneB_q, toneB_d;
  logic               sirenDrive_q, sirenDrive_d;
  logic               sirenActive_q;
  logic               sirenTimedOut_q;
  logic               statusLed_q;
  logic               tick;
  logic               halfHit;
  logic               startSound;

  assign tick    = (tickCnt_q == TICK_LAST);
  assign halfHit = (halfCnt_q == (toneB_q ? HALF_B_LAST : HALF_A_LAST));

  // Next-state logic. Entry into SOUNDING is collected in startSound so that
  // IDLE and CHIRP share one full initialisation of the tone machinery.
  always_comb begin
    state_d      = state_q;
    tickCnt_d    = tick ? '0 : tickCnt_q + 1'b1;
    halfCnt_d    = halfCnt_q;
    warbleCnt_d  = warbleCnt_q;
    onTicks_d    = onTicks_q;
    toneB_d      = toneB_q;
    sirenDrive_d = sirenDrive_q;
    startSound   = 1'b0;
`ifdef ALARM_CHIRP_EN
    chirpCnt_d   = chirpCnt_q;
`endif

    case (state_q)
      IDLE: begin
        sirenDrive_d = 1'b0;
        if (bus.sirenRequest) begin
          startSound = 1'b1;
        end
`ifdef ALARM_CHIRP_EN
        else if (bus.statusRequest && !statusLed_q) begin
          state_d      = CHIRP;
          tickCnt_d    = '0;
          halfCnt_d    = '0;
          toneB_d      = 1'b0;
          sirenDrive_d = 1'b1;
          chirpCnt_d   = '0;
        end
`endif
      end

      SOUNDING: begin
        if (!bus.sirenRequest) begin
          state_d      = IDLE;
          sirenDrive_d = 1'b0;
        end else if (tick && onTicks_q == ON_LAST) begin
          state_d      = CUTOFF;
          sirenDrive_d = 1'b0;
        end else begin
          if (halfHit) begin
            sirenDrive_d = ~sirenDrive_q;
            halfCnt_d    = '0;
          end else begin
            halfCnt_d = halfCnt_q + 1'b1;
          end
          if (tick) begin
            if (onTicks_q != '1) begin
              onTicks_d = onTicks_q + 1'b1;
            end
            // A tone swap restarts the half period and holds the output
            // level, overriding any toggle due in the same cycle.
            if (warbleCnt_q == WARB_LAST) begin
              toneB_d      = ~toneB_q;
              warbleCnt_d  = '0;
              halfCnt_d    = '0;
              sirenDrive_d = sirenDrive_q;
            end else begin
              warbleCnt_d = warbleCnt_q + 1'b1;
            end
          end
        end
      end

      CUTOFF: begin
        sirenDrive_d = 1'b0;
        if (!bus.sirenRequest) begin
          state_d = IDLE;
        end
      end

`ifdef ALARM_CHIRP_EN
      CHIRP: begin
        if (bus.sirenRequest) begin
          startSound = 1'b1;
        end else if (tick && chirpCnt_q == CHIRP_LAST) begin
          state_d      = IDLE;
          sirenDrive_d = 1'b0;
        end else begin
          if (halfHit) begin
            sirenDrive_d = ~sirenDrive_q;
            halfCnt_d    = '0;
          end else begin
            halfCnt_d = halfCnt_q + 1'b1;
          end
          if (tick) begin
            chirpCnt_d = chirpCnt_q + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d      = IDLE;
        sirenDrive_d = 1'b0;
      end
    endcase

    if (startSound) begin
      state_d      = SOUNDING;
      tickCnt_d    = '0;
      halfCnt_d    = '0;
      warbleCnt_d  = '0;
      onTicks_d    = '0;
      toneB_d      = 1'b0;
      sirenDrive_d = 1'b1;
    end
  end

  // State and output registers; status flags are decoded from the next state
  // so they line up with the state they describe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      tickCnt_q       <= '0;
      halfCnt_q       <= '0;
      warbleCnt_q     <= '0;
      onTicks_q       <= '0;
      toneB_q         <= 1'b0;
      sirenDrive_q    <= 1'b0;
      sirenActive_q   <= 1'b0;
      sirenTimedOut_q <= 1'b0;
      statusLed_q     <= 1'b0;
`ifdef ALARM_CHIRP_EN
      chirpCnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      tickCnt_q       <= tickCnt_d;
      halfCnt_q       <= halfCnt_d;
      warbleCnt_q     <= warbleCnt_d;
      onTicks_q       <= onTicks_d;
      toneB_q         <= toneB_d;
      sirenDrive_q    <= sirenDrive_d;
      sirenActive_q   <= (state_d == SOUNDING);
      sirenTimedOut_q <= (state_d == CUTOFF);
      statusLed_q     <= bus.statusRequest;
`ifdef ALARM_CHIRP_EN
      chirpCnt_q      <= chirpCnt_d;
`endif
    end
  end

  assign bus.sirenDrive    = sirenDrive_q;
  assign bus.sirenActive   = sirenActive_q;
  assign bus.sirenTimedOut = sirenTimedOut_q;
  assign bus.statusLed     = statusLed_q;

endmodule

// File: tb/tb_alarm_output_driver.sv
// -----------------------------------------------------------------------------
// tb_alarm_output_driver
//
// Purpose: self-checking bench for alarm_output_driver. A behavioural model
// tracks the alarm mode and the number of cycles spent in it, and derives the
// expected siren waveform arithmetically from that cycle count.
// Honours ALARM_CHIRP_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_alarm_output_driver;

  localparam int TICK_DIV     = 4;
  localparam int TONE_A_HALF  = 2;
  localparam int TONE_B_HALF  = 3;
  localparam int WARBLE_TICKS = 5;
  localparam int MAX_ON_TICKS = 40;
  localparam int CHIRP_TICKS  = 3;

`ifdef ALARM_CHIRP_EN
  localparam bit CHIRP_EN = 1'b1;
`else
  localparam bit CHIRP_EN = 1'b0;
`endif

  localparam int SEG_CYCLES   = WARBLE_TICKS * TICK_DIV;
  localparam int CUT_CYCLES   = MAX_ON_TICKS * TICK_DIV;
  localparam int CHIRP_CYCLES = CHIRP_TICKS * TICK_DIV;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alarm_output_driver_if bus ();

  alarm_output_driver #(
    .TICK_DIV    (TICK_DIV),
    .TONE_A_HALF (TONE_A_HALF),
    .TONE_B_HALF (TONE_B_HALF),
    .WARBLE_TICKS(WARBLE_TICKS),
    .MAX_ON_TICKS(MAX_ON_TICKS),
    .CHIRP_TICKS (CHIRP_TICKS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running 10-unit clock; outputs are sampled on the falling edge.
  always #5 clock = ~clock;

  typedef enum int {M_IDLE, M_SOUND, M_CUT, M_CHIRP} mode_t;

  mode_t mMode = M_IDLE;
  int    mN    = 0;
  bit    mLed  = 1'b0;

  // Reference model: the mode plus cycles elapsed since entering it.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mMode <= M_IDLE;
      mN    <= 0;
      mLed  <= 1'b0;
    end else begin
      mLed <= bus.statusRequest;
      case (mMode)
        M_IDLE: begin
          if (bus.sirenRequest) begin
            mMode <= M_SOUND;
            mN    <= 0;
          end else if (CHIRP_EN && bus.statusRequest && !mLed) begin
            mMode <= M_CHIRP;
            mN    <= 0;
          end
        end
        M_SOUND: begin
          if (!bus.sirenRequest) mMode <= M_IDLE;
          else if (mN + 1 == CUT_CYCLES) mMode <= M_CUT;
          else mN <= mN + 1;
        end
        M_CUT: begin
          if (!bus.sirenRequest) mMode <= M_IDLE;
        end
        default: begin
          if (bus.sirenRequest) begin
            mMode <= M_SOUND;
            mN    <= 0;
          end else if (mN + 1 == CHIRP_CYCLES) mMode <= M_IDLE;
          else mN <= mN + 1;
        end
      endcase
    end
  end

  function automatic int halfFor(input int seg);
    return (seg % 2 == 0) ? TONE_A_HALF : TONE_B_HALF;
  endfunction

  // Siren level n cycles into sounding: each warble segment toggles every
  // half period and hands its final level on to the next segment.
  function automatic bit toneLevel(input int n);
    int seg = n / SEG_CYCLES;
    int pos = n % SEG_CYCLES;
    bit lvl = 1'b1;
    for (int s = 0; s < seg; s++) lvl ^= bit'(((SEG_CYCLES - 1) / halfFor(s)) % 2);
    return lvl ^ bit'((pos / halfFor(seg)) % 2);
  endfunction

  function automatic logic [3:0] expVec();
    bit drv;
    drv = 1'b0;
    if (mMode == M_SOUND) drv = toneLevel(mN);
    else if (mMode == M_CHIRP) drv = bit'(((mN / TONE_A_HALF) % 2) == 0);
    return {drv, mMode == M_SOUND, mMode == M_CUT, mLed};
  endfunction

  wire [3:0] dutVec = {bus.sirenDrive, bus.sirenActive, bus.sirenTimedOut, bus.statusLed};

  // Asynchronous reset, then a quiet idle period.
  task automatic test_reset();
    bus.sirenRequest  = 1'b0;
    bus.statusRequest = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dutVec !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_async: dut=%b expected=%b", dutVec, 4'b0000);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== 4'b0000 || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL reset_idle cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
  endtask

  // Tone A: 2 high, 2 low from the first cycle after the request edge.
  task automatic test_tone_a();
    bus.sirenRequest = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.sirenDrive, bus.sirenActive} !== {bit'(((i / 2) % 2) == 0), 1'b1} ||
          dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL tone_a cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
  endtask

  // Keeps sounding across two warble swaps (A->B at 20 cycles, B->A at 40).
  task automatic test_warble();
    int highRun;
    int maxRun;
    highRun = 0;
    maxRun  = 0;
    for (int i = 12; i < 60; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL warble cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
      highRun = bus.sirenDrive ? highRun + 1 : 0;
      if (highRun > maxRun) maxRun = highRun;
    end
    checks++;
    if (maxRun !== TONE_B_HALF) begin
      errors++;
      $display("[TB] FAIL warble_tone_b_width: dut=%0d expected=%0d", maxRun, TONE_B_HALF);
    end
  endtask

  // Held request runs into the cutoff, then drop and re-raise.
  task automatic test_cutoff();
    for (int i = 60; i < CUT_CYCLES + 15; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL cutoff cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
    checks++;
    if ({bus.sirenDrive, bus.sirenActive, bus.sirenTimedOut} !== 3'b001) begin
      errors++;
      $display("[TB] FAIL cutoff_held: dut=%b expected=%b", dutVec, 4'b0010);
    end
    bus.sirenRequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== 4'b0000 || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL cutoff_release cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
    bus.sirenRequest = 1'b1;
    @(negedge clock);
    checks++;
    if (dutVec !== 4'b1100 || dutVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL cutoff_resound: dut=%b expected=%b", dutVec, 4'b1100);
    end
    bus.sirenRequest = 1'b0;
    @(negedge clock);
  endtask

  // Request drops on the very edge of the last tick; then a mid-tone reset.
  task automatic test_simultaneous();
    bit sawTimeout;
    sawTimeout = 1'b0;
    bus.sirenRequest = 1'b1;
    for (int i = 0; i < CUT_CYCLES; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL simul cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
      if (bus.sirenTimedOut) sawTimeout = 1'b1;
    end
    bus.sirenRequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== 4'b0000 || dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL simul_drop cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
      if (bus.sirenTimedOut) sawTimeout = 1'b1;
    end
    checks++;
    if (sawTimeout !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_no_timeout: dut=%b expected=%b", sawTimeout, 1'b0);
    end
    bus.sirenRequest = 1'b1;
    for (int i = 0; i < 29; i++) @(negedge clock);
    checks++;
    if (bus.sirenActive !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_before: dut=%b expected=%b", bus.sirenActive, 1'b1);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (dutVec !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL mid_reset_async: dut=%b expected=%b", dutVec, 4'b0000);
    end
    bus.sirenRequest = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL mid_reset_after cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
  endtask

  // Status rise while idle (chirp if enabled), then siren pre-empting a chirp.
  task automatic test_chirp();
    int highs;
    highs = 0;
    bus.statusRequest = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL chirp cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
      if (bus.sirenDrive) highs++;
    end
    checks++;
    if (highs !== (CHIRP_EN ? CHIRP_CYCLES / 2 : 0) || dutVec !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL chirp_length: dut=%0d/%b expected=%0d/%b", highs, dutVec,
               CHIRP_EN ? CHIRP_CYCLES / 2 : 0, 4'b0001);
    end
    bus.statusRequest = 1'b0;
    for (int i = 0; i < 3; i++) @(negedge clock);
    bus.statusRequest = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clock);
    bus.sirenRequest = 1'b1;
    @(negedge clock);
    checks++;
    if (dutVec !== 4'b1101 || dutVec !== expVec()) begin
      errors++;
      $display("[TB] FAIL chirp_preempt: dut=%b expected=%b", dutVec, 4'b1101);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL chirp_sound cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
    end
    bus.sirenRequest  = 1'b0;
    bus.statusRequest = 1'b0;
    @(negedge clock);
  endtask

  // Random request levels with random hold times, long enough to hit cutoff.
  task automatic test_random();
    int holdLeft;
    holdLeft = 1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      checks++;
      if (dutVec !== expVec()) begin
        errors++;
        $display("[TB] FAIL random cycle %0d: dut=%b expected=%b", i, dutVec, expVec());
      end
      holdLeft--;
      if (holdLeft == 0) begin
        bus.sirenRequest = 1'($urandom_range(0, 1));
        holdLeft = $urandom_range(1, 220);
      end
      if ($urandom_range(0, 15) == 0) bus.statusRequest = ~bus.statusRequest;
    end
  endtask

  initial begin
    $display("[TB] alarm_output_driver bench, chirp build = %0d", CHIRP_EN);
    test_reset();
    test_tone_a();
    test_warble();
    test_cutoff();
    test_simultaneous();
    test_chirp();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
